rip_branch_predictor_ctr: RTL and testbench

Parametrised gshare/bimodal direction predictor with N-bit saturating counters and a self-initialising pattern table.
- Adds a reset-time table clear FSM, write-first bypass and mispredict history recovery.
- Sits in the fetch stage: predicts at fetch and is trained from execute.
- Outputs a 1-cycle-latency prediction plus the index, counter and history checkpoint needed later for update/recovery.

---
 rtl/rip_branch_predictor_ctr.sv | 133 +++++++++++++
 tb/tb_rip_branch_predictor_ctr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rip_branch_predictor_ctr.sv
// Gshare/bimodal direction predictor: N-bit saturating counters, self-initialising table, write-first bypass.
// Optional RIP_BP_SPEC_HIST_EN: speculative global history with mispredict recovery.
module rip_branch_predictor_ctr #(
    parameter int unsigned INDEX_W  = 10,
    parameter int unsigned HIST_LEN = 8,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned PC_LSB   = 2,
    parameter int unsigned INIT_CTR = 1
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                ready,
    input  logic [31:0]         pc,
    input  logic                req,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [INDEX_W-1:0]  pred_index,
    output logic [CTR_W-1:0]    pred_ctr,
    output logic [HIST_LEN-1:0] pred_hist,
    input  logic                update,
    input  logic [INDEX_W-1:0]  update_index,
    input  logic [CTR_W-1:0]    update_ctr,
    input  logic [HIST_LEN-1:0] update_hist,
    input  logic                actual,
    input  logic                mispredict
);
    localparam int unsigned DEPTH = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state, state_next;
    logic [INDEX_W-1:0]  init_addr;
    logic [HIST_LEN-1:0] ghr, ghr_next;
    logic [CTR_W-1:0]    ctr_table [DEPTH];

    logic [INDEX_W-1:0]  idx;
    logic [CTR_W-1:0]    new_ctr;
    logic [CTR_W-1:0]    rd_ctr;
    logic                run_update;
    logic                wr_en;
    logic [INDEX_W-1:0]  wr_addr;
    logic [CTR_W-1:0]    wr_data;
    logic                unused_ok;

    assign unused_ok  = ^{pc, update_hist, mispredict};
    assign ready      = (state == ST_RUN);
    assign run_update = ready && update;

    always_comb begin
        idx = pc[PC_LSB +: INDEX_W] ^ INDEX_W'(ghr);
    end

    // Saturating increment/decrement of the counter value carried back from predict.
    always_comb begin
        new_ctr = update_ctr;
        if (actual) begin
            if (update_ctr != CTR_MAX) new_ctr = update_ctr + CTR_W'(1);
        end else begin
            if (update_ctr != '0) new_ctr = update_ctr - CTR_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (&init_addr) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Single write port: init sweep owns it until ready, then training updates.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = init_addr;
        wr_data = CTR_W'(INIT_CTR);
        if (state == ST_INIT) begin
            wr_en = 1'b1;
        end else if (update) begin
            wr_en   = 1'b1;
            wr_addr = update_index;
            wr_data = new_ctr;
        end
    end

    always_comb begin
        rd_ctr = ctr_table[idx];
        if (run_update && (update_index == idx)) rd_ctr = new_ctr;
    end

`ifdef RIP_BP_SPEC_HIST_EN
    // Recovery from a mispredict wins over the speculative shift of the same cycle.
    always_comb begin
        ghr_next = ghr;
        if (run_update && mispredict) ghr_next = HIST_LEN'({update_hist, actual});
        else if (pred_valid)          ghr_next = HIST_LEN'({ghr, pred_taken});
    end
`else
    always_comb begin
        ghr_next = ghr;
        if (run_update) ghr_next = HIST_LEN'({ghr, actual});
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_INIT;
            init_addr  <= '0;
            ghr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
            pred_ctr   <= '0;
            pred_hist  <= '0;
        end else begin
            state      <= state_next;
            ghr        <= ghr_next;
            pred_valid <= ready && req;
            if (state == ST_INIT) init_addr <= init_addr + INDEX_W'(1);
            if (ready && req) begin
                pred_index <= idx;
                pred_hist  <= ghr;
                pred_ctr   <= rd_ctr;
                pred_taken <= rd_ctr[CTR_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ctr_table[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_rip_branch_predictor_ctr.sv
// Self-checking bench for rip_branch_predictor_ctr: hand vectors, init/re-init timing, randomized run vs model.
// Honours RIP_BP_SPEC_HIST_EN to select the history-update rules of the reference model.
module tb_rip_branch_predictor_ctr;
    localparam int unsigned INDEX_W  = 10;
    localparam int unsigned HIST_LEN = 8;
    localparam int unsigned CTR_W    = 2;
    localparam int unsigned PC_LSB   = 2;
    localparam int unsigned INIT_CTR = 1;
    localparam int unsigned DEPTH    = 1 << INDEX_W;
    localparam int unsigned CMAX     = (1 << CTR_W) - 1;
    localparam int unsigned HALF     = 1 << (CTR_W - 1);
    localparam int unsigned HMOD     = 1 << HIST_LEN;

    logic        clk = 1'b0;
    logic        rstn, req, update, actual, mispredict;
    logic [31:0] pc;
    logic [9:0]  update_index;
    logic [1:0]  update_ctr;
    logic [7:0]  update_hist;
    logic        ready, pred_valid, pred_taken;
    logic [9:0]  pred_index;
    logic [1:0]  pred_ctr;
    logic [7:0]  pred_hist;

    rip_branch_predictor_ctr #(
        .INDEX_W(INDEX_W), .HIST_LEN(HIST_LEN), .CTR_W(CTR_W), .PC_LSB(PC_LSB), .INIT_CTR(INIT_CTR)
    ) dut (
        .clk(clk), .rstn(rstn), .ready(ready), .pc(pc), .req(req),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
        .pred_ctr(pred_ctr), .pred_hist(pred_hist), .update(update),
        .update_index(update_index), .update_ctr(update_ctr), .update_hist(update_hist),
        .actual(actual), .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts cycles since reset release, keeps counters as plain integers.
    int unsigned m_tbl [DEPTH];
    int unsigned m_cyc, m_ghr, m_idx, m_ctr, m_hist;
    bit          m_valid, m_taken;

    function automatic void model_edge();
        int unsigned i, nc;
        bit pv, pt;
        if (!rstn) begin
            m_cyc = 0; m_ghr = 0; m_valid = 0; m_taken = 0; m_idx = 0; m_ctr = 0; m_hist = 0;
            return;
        end
        if (m_cyc < DEPTH) begin
            m_cyc++;
            if (m_cyc == DEPTH) foreach (m_tbl[k]) m_tbl[k] = INIT_CTR;
            m_valid = 0;
            return;
        end
        i = ((int'(pc) >> PC_LSB) & (DEPTH - 1)) ^ m_ghr;
        if (update) begin
            if (actual) nc = (update_ctr + 1 > CMAX) ? CMAX : update_ctr + 1;
            else        nc = (update_ctr == 0) ? 0 : update_ctr - 1;
            m_tbl[update_index] = nc;
        end
        pv = m_valid;
        pt = m_taken;
        if (req) begin
            m_valid = 1; m_idx = i; m_hist = m_ghr; m_ctr = m_tbl[i]; m_taken = (m_ctr >= HALF);
        end else begin
            m_valid = 0;
        end
`ifdef RIP_BP_SPEC_HIST_EN
        if (update && mispredict) m_ghr = ((update_hist * 2) + actual) % HMOD;
        else if (pv)              m_ghr = ((m_ghr * 2) + pt) % HMOD;
`else
        if (update) m_ghr = ((m_ghr * 2) + actual) % HMOD;
`endif
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("ready", ready, m_cyc >= DEPTH);
        chk("pred_valid", pred_valid, m_valid);
        chk("pred_index", pred_index, m_idx);
        chk("pred_ctr", pred_ctr, m_ctr);
        chk("pred_taken", pred_taken, m_taken);
        chk("pred_hist", pred_hist, m_hist);
    endtask

    typedef struct packed {
        logic        req;
        logic [31:0] pc;
        logic        upd;
        logic [9:0]  uidx;
        logic [1:0]  uctr;
        logic        act;
        logic        mis;
        logic [7:0]  uhist;
        logic        ev;
        logic [9:0]  eidx;
        logic [1:0]  ectr;
        logic        etk;
        logic [7:0]  ehist;
    } vec_t;

    vec_t va [16];
    vec_t vb [9];

    task automatic run_vec(input vec_t v, input string tag);
        req = v.req; pc = v.pc; update = v.upd; update_index = v.uidx; update_ctr = v.uctr;
        actual = v.act; mispredict = v.mis; update_hist = v.uhist;
        step();
        chk({tag, "_valid"}, pred_valid, v.ev);
        chk({tag, "_index"}, pred_index, v.eidx);
        chk({tag, "_ctr"},   pred_ctr,   v.ectr);
        chk({tag, "_taken"}, pred_taken, v.etk);
        chk({tag, "_hist"},  pred_hist,  v.ehist);
    endtask

    task automatic idle_inputs();
        req = 0; pc = '0; update = 0; update_index = '0; update_ctr = '0;
        actual = 0; mispredict = 0; update_hist = '0;
    endtask

    task automatic init_run(input string tag);
        int first_rdy;
        first_rdy = 0;
        req = 1;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            pc = $urandom;
            step();
            if (ready && first_rdy == 0) first_rdy = k;
        end
        chk(tag, first_rdy, DEPTH);
        req = 0;
    endtask

    initial begin
        // Indexing, saturation both ways, bypass; history moves identically in both history modes.
        va[0]  = '{1'b0, 32'h0,   1'b1, 10'h100, 2'd1, 1'b1, 1'b1, 8'h00, 1'b0, 10'h000, 2'd0, 1'b0, 8'h00};
        va[1]  = '{1'b0, 32'h0,   1'b1, 10'h100, 2'd2, 1'b0, 1'b1, 8'h01, 1'b0, 10'h000, 2'd0, 1'b0, 8'h00};
        va[2]  = '{1'b0, 32'h0,   1'b1, 10'h100, 2'd1, 1'b1, 1'b1, 8'h02, 1'b0, 10'h000, 2'd0, 1'b0, 8'h00};
        va[3]  = '{1'b1, 32'h40,  1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h015, 2'd1, 1'b0, 8'h05};
        va[4]  = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd1, 1'b1, 1'b1, 8'h05, 1'b0, 10'h015, 2'd1, 1'b0, 8'h05};
        va[5]  = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd2, 1'b1, 1'b1, 8'h0B, 1'b0, 10'h015, 2'd1, 1'b0, 8'h05};
        va[6]  = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd3, 1'b1, 1'b1, 8'h17, 1'b0, 10'h015, 2'd1, 1'b0, 8'h05};
        va[7]  = '{1'b1, 32'hA8,  1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h005, 2'd3, 1'b1, 8'h2F};
        va[8]  = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd3, 1'b0, 1'b1, 8'h2F, 1'b0, 10'h005, 2'd3, 1'b1, 8'h2F};
        va[9]  = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd2, 1'b0, 1'b1, 8'h5E, 1'b0, 10'h005, 2'd3, 1'b1, 8'h2F};
        va[10] = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd1, 1'b0, 1'b1, 8'hBC, 1'b0, 10'h005, 2'd3, 1'b1, 8'h2F};
        va[11] = '{1'b0, 32'h0,   1'b1, 10'h005, 2'd0, 1'b0, 1'b1, 8'h78, 1'b0, 10'h005, 2'd3, 1'b1, 8'h2F};
        va[12] = '{1'b1, 32'h3D4, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h005, 2'd0, 1'b0, 8'hF0};
        va[13] = '{1'b1, 32'h388, 1'b1, 10'h012, 2'd1, 1'b1, 1'b1, 8'hF0, 1'b1, 10'h012, 2'd2, 1'b1, 8'hF0};
        va[14] = '{1'b0, 32'h0,   1'b1, 10'h012, 2'd2, 1'b0, 1'b1, 8'hE1, 1'b0, 10'h012, 2'd2, 1'b1, 8'hF0};
        va[15] = '{1'b0, 32'h0,   1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h012, 2'd2, 1'b1, 8'hF0};

        // History behaviour from a fresh table: predictions shift (or not) and mispredict restores.
`ifdef RIP_BP_SPEC_HIST_EN
        vb[2] = '{1'b1, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h000, 2'd2, 1'b1, 8'h00};
        vb[3] = '{1'b1, 32'h4, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h001, 2'd2, 1'b1, 8'h00};
        vb[4] = '{1'b1, 32'h8, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h003, 2'd1, 1'b0, 8'h01};
        vb[5] = '{1'b0, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h003, 2'd1, 1'b0, 8'h01};
        vb[6] = '{1'b1, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h006, 2'd1, 1'b0, 8'h06};
        vb[7] = '{1'b0, 32'h0, 1'b1, 10'h030, 2'd1, 1'b0, 1'b1, 8'h01, 1'b0, 10'h006, 2'd1, 1'b0, 8'h06};
        vb[8] = '{1'b1, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h002, 2'd1, 1'b0, 8'h02};
`else
        vb[2] = '{1'b1, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h003, 2'd1, 1'b0, 8'h03};
        vb[3] = '{1'b1, 32'h4, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h002, 2'd1, 1'b0, 8'h03};
        vb[4] = '{1'b1, 32'h8, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h001, 2'd2, 1'b1, 8'h03};
        vb[5] = '{1'b0, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h001, 2'd2, 1'b1, 8'h03};
        vb[6] = '{1'b1, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h003, 2'd1, 1'b0, 8'h03};
        vb[7] = '{1'b0, 32'h0, 1'b1, 10'h030, 2'd1, 1'b0, 1'b1, 8'h01, 1'b0, 10'h003, 2'd1, 1'b0, 8'h03};
        vb[8] = '{1'b1, 32'h0, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h006, 2'd1, 1'b0, 8'h06};
`endif
        vb[0] = '{1'b0, 32'h0, 1'b1, 10'h000, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 2'd0, 1'b0, 8'h00};
        vb[1] = '{1'b0, 32'h0, 1'b1, 10'h001, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 2'd0, 1'b0, 8'h00};

        idle_inputs();
        rstn = 0;
        for (int k = 0; k < 3; k++) step();
        chk("rst_ready", ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_hist", pred_hist, 0);

        rstn = 1;
        init_run("init_len");

        for (int r = 0; r < 16; r++) run_vec(va[r], $sformatf("vecA%0d", r));

        // Reset in the middle of the init sweep restarts it from address 0.
        rstn = 0;
        step(); step();
        rstn = 1;
        for (int k = 0; k < 300; k++) step();
        rstn = 0;
        step();
        rstn = 1;
        init_run("reinit_len");

        for (int r = 0; r < 9; r++) run_vec(vb[r], $sformatf("vecB%0d", r));

        for (int n = 0; n < 4000; n++) begin
            rstn = !(n == 1200 || n == 1201);
            req = 1'($urandom);
            pc = $urandom;
            update = 1'($urandom);
            actual = 1'($urandom);
            mispredict = 1'($urandom);
            update_hist = 8'($urandom);
            update_ctr = 2'($urandom);
            case ($urandom_range(0, 2))
                0: update_index = 10'(((pc >> PC_LSB) & (DEPTH - 1)) ^ m_ghr);
                1: update_index = 10'(m_idx);
                default: update_index = 10'($urandom);
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
